// File: rtl/user_input_decoder.sv
// PS/2 scan-code to game-event decoder: prefix parser, held-key tracking, show-ahead event FIFO.
// Define USER_INPUT_AUTOREPEAT_EN to build in auto-repeat and typematic suppression.

package user_input_decoder_pkg;
  typedef enum logic [2:0] {
    EV_NONE     = 3'd0,
    EV_NEW_GAME = 3'd1,
    EV_ROTATE   = 3'd2,
    EV_LEFT     = 3'd3,
    EV_RIGHT    = 3'd4,
    EV_DOWN     = 3'd5
  } user_event_t;
endpackage

module user_input_decoder
  import user_input_decoder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [7:0]                        ps2_key_data_i,
  input  logic                              ps2_key_data_en_i,
  input  logic                              user_event_rd_req_i,
  output user_event_t                       user_event_o,
  output logic                              user_event_ready_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   user_event_count_o,
  output logic [4:0]                        key_held_o,
  output logic                              overflow_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0]  KeyExt = 8'hE0;
  localparam logic [7:0]  KeyBrk = 8'hF0;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_params
    $error("user_input_decoder: illegal parameter value");
  end

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  state_e      state_q;
  logic [4:0]  held_q, held_d;
  logic        push_q, push_d;
  user_event_t push_ev_q, push_ev_d;
  logic        is_ext, is_brk, is_code, key_hit, make_valid, brk_valid, parser_push;
  logic [4:0]  key_sel;
  user_event_t key_ev;

  always_comb begin
    is_ext  = (state_q == StExt) || (state_q == StExtBrk);
    is_brk  = (state_q == StBrk) || (state_q == StExtBrk);
    is_code = ps2_key_data_en_i && (ps2_key_data_i != KeyExt) && (ps2_key_data_i != KeyBrk);
    key_sel = '0;
    key_ev  = EV_NONE;
    if (!is_ext) begin
      if (ps2_key_data_i == 8'h31) begin
        key_sel = 5'b10000;
        key_ev  = EV_NEW_GAME;
      end
    end else begin
      unique case (ps2_key_data_i)
        8'h6B:   begin key_sel = 5'b00001; key_ev = EV_LEFT;   end
        8'h74:   begin key_sel = 5'b00010; key_ev = EV_RIGHT;  end
        8'h72:   begin key_sel = 5'b00100; key_ev = EV_DOWN;   end
        8'h75:   begin key_sel = 5'b01000; key_ev = EV_ROTATE; end
        default: ;
      endcase
    end
    key_hit    = key_sel != '0;
    make_valid = is_code && !is_brk && key_hit;
    brk_valid  = is_code && is_brk && key_hit;
    held_d     = held_q;
    if (make_valid) held_d = held_q | key_sel;
    if (brk_valid)  held_d = held_q & ~key_sel;
  end

`ifdef USER_INPUT_AUTOREPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = $clog2(RepMax);
  localparam logic [RepW-1:0] DelayThr  = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] PeriodThr = RepW'(REPEAT_PERIOD - 1);

  logic            rep_active_q, rep_first_q, pend_q, pend_d, rep_fire, rep_stop, rep_start;
  logic [RepW-1:0] rep_cnt_q, rep_thr;
  user_event_t     rep_ev_q, pend_ev_q, pend_ev_d;

  always_comb begin
    // typematic makes of an already-held key are swallowed
    parser_push = make_valid && ((held_q & key_sel) == '0);
    rep_start   = parser_push && (key_sel[2:0] != '0);
    rep_stop    = brk_valid && (key_ev == rep_ev_q);
    rep_thr     = rep_first_q ? DelayThr : PeriodThr;
    rep_fire    = rep_active_q && (rep_cnt_q == rep_thr) && !rep_stop;
    push_d      = 1'b0;
    push_ev_d   = EV_NONE;
    pend_d      = pend_q;
    pend_ev_d   = pend_ev_q;
    if (parser_push) begin
      push_d    = 1'b1;
      push_ev_d = key_ev;
      if (rep_fire) begin
        pend_d    = 1'b1;
        pend_ev_d = rep_ev_q;
      end
    end else if (pend_q) begin
      push_d    = 1'b1;
      push_ev_d = pend_ev_q;
      pend_d    = rep_fire;
      pend_ev_d = rep_ev_q;
    end else if (rep_fire) begin
      push_d    = 1'b1;
      push_ev_d = rep_ev_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rep_active_q <= 1'b0;
      rep_first_q  <= 1'b0;
      rep_cnt_q    <= '0;
      rep_ev_q     <= EV_NONE;
      pend_q       <= 1'b0;
      pend_ev_q    <= EV_NONE;
    end else begin
      pend_q    <= pend_d;
      pend_ev_q <= pend_ev_d;
      if (rep_start) begin
        rep_active_q <= 1'b1;
        rep_first_q  <= 1'b1;
        rep_cnt_q    <= '0;
        rep_ev_q     <= key_ev;
      end else if (rep_stop) begin
        rep_active_q <= 1'b0;
      end else if (rep_active_q) begin
        if (rep_cnt_q == rep_thr) begin
          rep_cnt_q   <= '0;
          rep_first_q <= 1'b0;
        end else begin
          rep_cnt_q <= rep_cnt_q + RepW'(1);
        end
      end
    end
  end
`else
  always_comb begin
    parser_push = make_valid;
    push_d      = parser_push;
    push_ev_d   = key_ev;
  end
`endif

  // Parser FSM, held flags and the one-cycle push stage
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      held_q    <= '0;
      push_q    <= 1'b0;
      push_ev_q <= EV_NONE;
    end else begin
      held_q    <= held_d;
      push_q    <= push_d;
      push_ev_q <= push_ev_d;
      if (ps2_key_data_en_i) begin
        if (ps2_key_data_i == KeyExt)      state_q <= StExt;
        else if (ps2_key_data_i == KeyBrk) state_q <= is_ext ? StExtBrk : StBrk;
        else                               state_q <= StIdle;
      end
    end
  end

  user_event_t         mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q;
  logic                ovf_q, empty, full, do_pop, do_push;

  always_comb begin
    empty   = count_q == '0;
    full    = count_q == CntW'(FIFO_DEPTH);
    do_pop  = user_event_rd_req_i && !empty;
    do_push = push_q && (!full || do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_ev_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (!do_push && do_pop) count_q <= count_q - CntW'(1);
      if (push_q && !do_push) ovf_q <= 1'b1;
    end
  end

  assign user_event_o       = empty ? EV_NONE : mem_q[rd_ptr_q];
  assign user_event_ready_o = !empty;
  assign user_event_count_o = count_q;
  assign key_held_o         = held_q;
  assign overflow_o         = ovf_q;

endmodule

// File: tb/tb_user_input_decoder.sv
// Directed bench for user_input_decoder (FIFO_DEPTH=4, REPEAT_DELAY=50, REPEAT_PERIOD=20).
`timescale 1ns/1ps
module tb_user_input_decoder;
  import user_input_decoder_pkg::*;

`ifdef USER_INPUT_AUTOREPEAT_EN
  localparam bit AutoRep = 1'b1;
`else
  localparam bit AutoRep = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        en = 1'b0;
  logic        rd = 1'b0;
  user_event_t ev;
  logic        ready;
  logic [2:0]  count;
  logic [4:0]  held;
  logic        ovf;
  int          checks = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  user_input_decoder #(
    .FIFO_DEPTH   (4),
    .REPEAT_DELAY (50),
    .REPEAT_PERIOD(20)
  ) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .ps2_key_data_i     (data),
    .ps2_key_data_en_i  (en),
    .user_event_rd_req_i(rd),
    .user_event_o       (ev),
    .user_event_ready_o (ready),
    .user_event_count_o (count),
    .key_held_o         (held),
    .overflow_o         (ovf)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    data = b;
    en   = 1'b1;
    tick(1);
    en   = 1'b0;
  endtask

  task automatic pop();
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    checks++;
    if ({ev, ready, count, held, ovf} !== 13'd0) begin
      fails++;
      $display("FAIL reset_outputs: got ev=%0d rdy=%b cnt=%0d held=%b ovf=%b want all 0",
               ev, ready, count, held, ovf);
    end
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_left_press();
    do_reset();
    send(8'hE0);
    send(8'h6B);
    checks++;
    if (held !== 5'b00001) begin
      fails++; $display("FAIL left_held_rise: got %b want 00001", held);
    end
    checks++;
    if (ready !== 1'b0) begin
      fails++; $display("FAIL left_latency_early: ready got %b want 0", ready);
    end
    tick(1);
    checks++;
    if (ready !== 1'b1 || ev !== EV_LEFT) begin
      fails++; $display("FAIL left_latency: rdy=%b ev=%0d want rdy=1 ev=%0d", ready, ev, EV_LEFT);
    end
    tick(9);
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    checks++;
    if (held !== 5'b00000) begin
      fails++; $display("FAIL left_held_fall: got %b want 00000", held);
    end
    tick(60);
    checks++;
    if (count !== 3'd1 || ovf !== 1'b0) begin
      fails++; $display("FAIL left_single_event: cnt=%0d ovf=%b want cnt=1 ovf=0", count, ovf);
    end
    pop();
    checks++;
    if (ready !== 1'b0 || ev !== EV_NONE) begin
      fails++; $display("FAIL left_pop_empty: rdy=%b ev=%0d want 0/0", ready, ev);
    end
  endtask

  task automatic test_typematic();
    do_reset();
    send(8'hE0);
    send(8'h6B);
    tick(1);
    send(8'hE0);
    send(8'h6B);
    tick(2);
    checks++;
    if (count !== (AutoRep ? 3'd1 : 3'd2)) begin
      fails++;
      $display("FAIL typematic_count: got %0d want %0d", count, AutoRep ? 1 : 2);
    end
  endtask

  task automatic test_new_game();
    do_reset();
    send(8'h31);
    checks++;
    if (held !== 5'b10000) begin
      fails++; $display("FAIL newgame_held: got %b want 10000", held);
    end
    send(8'hF0);
    send(8'h31);
    send(8'h6B);
    tick(3);
    checks++;
    if (count !== 3'd1 || ev !== EV_NEW_GAME || held !== 5'b00000) begin
      fails++;
      $display("FAIL newgame_event: cnt=%0d ev=%0d held=%b want cnt=1 ev=%0d held=00000",
               count, ev, held, EV_NEW_GAME);
    end
  endtask

  task automatic test_repeat();
    do_reset();
    send(8'hE0);
    send(8'h72);
    tick(1);
    checks++;
    if (count !== 3'd1 || ev !== EV_DOWN) begin
      fails++; $display("FAIL repeat_press: cnt=%0d ev=%0d want 1/%0d", count, ev, EV_DOWN);
    end
    tick(49);
    checks++;
    if (count !== 3'd1) begin
      fails++; $display("FAIL repeat_before_delay: cnt=%0d want 1", count);
    end
    tick(1);
    checks++;
    if (count !== (AutoRep ? 3'd2 : 3'd1)) begin
      fails++; $display("FAIL repeat_first: cnt=%0d want %0d", count, AutoRep ? 2 : 1);
    end
    tick(19);
    checks++;
    if (count !== (AutoRep ? 3'd2 : 3'd1)) begin
      fails++; $display("FAIL repeat_before_period: cnt=%0d want %0d", count, AutoRep ? 2 : 1);
    end
    tick(1);
    checks++;
    if (count !== (AutoRep ? 3'd3 : 3'd1)) begin
      fails++; $display("FAIL repeat_second: cnt=%0d want %0d", count, AutoRep ? 3 : 1);
    end
    tick(20);
    checks++;
    if (count !== (AutoRep ? 3'd4 : 3'd1)) begin
      fails++; $display("FAIL repeat_third: cnt=%0d want %0d", count, AutoRep ? 4 : 1);
    end
    tick(6);
    send(8'hE0);
    send(8'hF0);
    send(8'h72);
    tick(40);
    checks++;
    if (count !== (AutoRep ? 3'd4 : 3'd1) || ovf !== 1'b0 || held !== 5'b00000) begin
      fails++;
      $display("FAIL repeat_stop: cnt=%0d ovf=%b held=%b want cnt=%0d ovf=0 held=00000",
               count, ovf, held, AutoRep ? 4 : 1);
    end
    for (int i = 0; i < (AutoRep ? 4 : 1); i++) begin
      checks++;
      if (ev !== EV_DOWN) begin
        fails++; $display("FAIL repeat_pop%0d: ev=%0d want %0d", i, ev, EV_DOWN);
      end
      pop();
    end
    checks++;
    if (ready !== 1'b0) begin
      fails++; $display("FAIL repeat_drained: rdy=%b want 0", ready);
    end
  endtask

  task automatic test_coincide();
    user_event_t exp [3];
    exp = '{EV_DOWN, EV_ROTATE, EV_DOWN};
    do_reset();
    send(8'hE0);
    send(8'h72);
    tick(48);
    send(8'hE0);
    send(8'h75);
    tick(1);
    checks++;
    if (count !== 3'd2) begin
      fails++; $display("FAIL coincide_parser_first: cnt=%0d want 2", count);
    end
    tick(1);
    checks++;
    if (count !== (AutoRep ? 3'd3 : 3'd2)) begin
      fails++; $display("FAIL coincide_pending: cnt=%0d want %0d", count, AutoRep ? 3 : 2);
    end
    for (int i = 0; i < (AutoRep ? 3 : 2); i++) begin
      checks++;
      if (ev !== exp[i]) begin
        fails++; $display("FAIL coincide_order%0d: ev=%0d want %0d", i, ev, exp[i]);
      end
      pop();
    end
    checks++;
    if (ready !== 1'b0) begin
      fails++; $display("FAIL coincide_drained: rdy=%b want 0", ready);
    end
  endtask

  task automatic test_overflow();
    user_event_t exp [4];
    exp = '{EV_NEW_GAME, EV_ROTATE, EV_LEFT, EV_RIGHT};
    do_reset();
    send(8'h31);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'h74);
    send(8'hE0); send(8'h72);
    tick(2);
    checks++;
    if (count !== 3'd4 || ovf !== 1'b1) begin
      fails++; $display("FAIL overflow_full: cnt=%0d ovf=%b want cnt=4 ovf=1", count, ovf);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ev !== exp[i]) begin
        fails++; $display("FAIL overflow_order%0d: ev=%0d want %0d", i, ev, exp[i]);
      end
      pop();
    end
    checks++;
    if (ready !== 1'b0 || ev !== EV_NONE || ovf !== 1'b1) begin
      fails++;
      $display("FAIL overflow_drained: rdy=%b ev=%0d ovf=%b want 0/0/1", ready, ev, ovf);
    end
  endtask

  task automatic test_push_pop_full();
    user_event_t exp [4];
    exp = '{EV_ROTATE, EV_LEFT, EV_RIGHT, EV_NEW_GAME};
    do_reset();
    send(8'h31);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'h74);
    tick(1);
    send(8'hF0);
    send(8'h31);
    send(8'h31);
    pop();
    checks++;
    if (count !== 3'd4 || ovf !== 1'b0) begin
      fails++; $display("FAIL pushpop_full: cnt=%0d ovf=%b want cnt=4 ovf=0", count, ovf);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ev !== exp[i]) begin
        fails++; $display("FAIL pushpop_order%0d: ev=%0d want %0d", i, ev, exp[i]);
      end
      pop();
    end
  endtask

  task automatic test_empty_pop();
    do_reset();
    pop();
    checks++;
    if (count !== 3'd0 || ready !== 1'b0) begin
      fails++; $display("FAIL empty_pop: cnt=%0d rdy=%b want 0/0", count, ready);
    end
    send(8'h31);
    tick(1);
    checks++;
    if (count !== 3'd1 || ev !== EV_NEW_GAME) begin
      fails++;
      $display("FAIL empty_pop_recover: cnt=%0d ev=%0d want 1/%0d", count, ev, EV_NEW_GAME);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(8'h31);
    tick(1);
    send(8'hE0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ev, ready, count, held, ovf} !== 13'd0) begin
      fails++;
      $display("FAIL reset_mid_outputs: ev=%0d rdy=%b cnt=%0d held=%b ovf=%b want all 0",
               ev, ready, count, held, ovf);
    end
    tick(1);
    rst_n = 1'b1;
    tick(1);
    send(8'h6B);
    tick(3);
    checks++;
    if (count !== 3'd0 || held !== 5'b00000) begin
      fails++; $display("FAIL reset_mid_prefix: cnt=%0d held=%b want 0/00000", count, held);
    end
  endtask

  initial begin
    test_reset();
    test_left_press();
    test_typematic();
    test_new_game();
    test_repeat();
    test_coincide();
    test_overflow();
    test_push_pop_full();
    test_empty_pop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/user_input_decoder.md
# user_input_decoder

Single-clock PS/2 scan-code decoder producing `user_event_t` game events for the main logic, with full make/break/extended-prefix parsing, per-key held-state tracking, internal auto-repeat and a parametrised show-ahead event FIFO. It sits between the PS/2 byte receiver, already in `clk_i` domain, and the game FSM, which pops events with a read-request handshake.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: event FIFO entries; power of two, 2..64.
- `REPEAT_DELAY`, 25_000_000: cycles from first press to first auto-repeat; ≥2.
- `REPEAT_PERIOD`, 5_000_000: cycles between subsequent auto-repeats; ≥2.

Ports:
- `clk_i` in 1: single clock for all logic.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `ps2_key_data_i` in 8: received scan-code byte.
- `ps2_key_data_en_i` in 1: byte strobe, one cycle per byte.
- `user_event_rd_req_i` in 1: pop head event.
- `user_event_o` out `$bits(user_event_t)`: head event, show-ahead.
- `user_event_ready_o` out 1: FIFO non-empty.
- `user_event_count_o` out `$clog2(FIFO_DEPTH+1)`: FIFO occupancy.
- `key_held_o` out 5: held flags `{new_game, rotate, down, right, left}`.
- `overflow_o` out 1: sticky; an event was dropped on full.

## Operation
- Key map: `31`→EV_NEW_GAME; `E0 75`→EV_ROTATE; `E0 6B`→EV_LEFT; `E0 74`→EV_RIGHT; `E0 72`→EV_DOWN. Non-extended `75/6B/74/72` (keypad) are unmapped. All other codes are ignored.
- Parser FSM, advancing only on `ps2_key_data_en_i`:
  - IDLE: `E0`→EXT; `F0`→BRK; else make(code, ext=0)→IDLE.
  - EXT: `F0`→EXT_BRK; `E0`→EXT; else make(code, ext=1)→IDLE.
  - BRK: `E0`→EXT; `F0`→BRK; else break(code, ext=0)→IDLE.
  - EXT_BRK: `E0`→EXT; `F0`→EXT_BRK; else break(code, ext=1)→IDLE.
- Make of a mapped key not held: push event, set held bit. Repeatable keys are LEFT/RIGHT/DOWN; pressing one makes it the repeat key and restarts the repeat counter.
- Make of a mapped key already held, which is keyboard typematic: no push.
- Break of a mapped key: clear held bit, no push. If it is the repeat key, repeat stops. Repeat does not resume on another still-held key.
- Auto-repeat: counter counts from 0 after a press. At `REPEAT_DELAY-1` it pushes the repeat key's event and reloads. It then pushes every `REPEAT_PERIOD` cycles while the key is held.
- Parser push and repeat push in the same cycle: the parser wins. The repeat event is held pending and pushed the next cycle. At most one pending event is held.
- FIFO push while full without a pop: event dropped, `overflow_o` set until reset. Push and pop in the same cycle while full: push accepted, count unchanged.
- `user_event_rd_req_i` while empty: ignored. `user_event_o` is forced to `'0` while empty.

## Timing
- Reset values: `user_event_o`=0, `user_event_ready_o`=0, `user_event_count_o`=0, `key_held_o`=0, `overflow_o`=0. Parser is in IDLE, repeat is idle, pending is clear.
- Reset is asserted asynchronously, and released synchronously to `clk_i`. Reset mid-sequence discards partial prefixes, FIFO contents and held state.
- Latency: final code byte strobed in cycle N; the event is visible at `user_event_o`, with ready high, in cycle N+2 if the FIFO was empty.
- Pop: the head advances, or ready drops, in the cycle after `rd_req` is sampled high. The count updates in the same edge.
- Back-to-back strobes, one byte per cycle, are fully supported.

## Configuration
- `USER_INPUT_AUTOREPEAT_EN` defined: auto-repeat logic as above. Keyboard typematic makes are suppressed.
- Undefined: the repeat counter and pending logic are removed. Every make of a mapped key pushes an event, including typematic repeats. Held tracking and `key_held_o` remain.

## Test plan
- Bytes `E0 6B`, then `E0 F0 6B` after 10 cycles: exactly one EV_LEFT. `key_held_o[0]` rises then falls. No repeat occurs if released before `REPEAT_DELAY`, run with `REPEAT_DELAY=50`, `REPEAT_PERIOD=20`.
- Macro on, `E0 72` held for 100 cycles: EV_DOWN at press, then repeats at press+50, +70, +90. Repeats stop after `E0 F0 72`.
- `31`, then `F0 31`: one EV_NEW_GAME. Bare `6B`: no event.
- `FIFO_DEPTH=4`, no reads, 5 distinct presses: count=4 and `overflow_o`=1. Popping 4 times returns the first 4 events in order, then ready=0.
- Repeat expiry coinciding with a parser make of `E0 75`: EV_ROTATE is pushed first and EV_DOWN one cycle later.
- Assert `rst_n_i` mid-stream after an `E0`, then send `6B`: no event. All outputs read 0 during reset.
